// File: rtl/hamming_decoder.sv
// Streaming Hamming [7,4] single-error-correcting decoder with a two-stage valid/ready pipeline.
// Define HAMMING_DEC_STATS_EN to build the saturating word/correction counters.
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       in_codeword,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] corr_count
);

  logic [2:0] in_syn;
  logic       s1_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;
  logic       s1_move;
  logic [7:0] syn_onehot;
  logic [6:0] fixed;

  // Each syndrome bit covers the positions whose index has that bit set.
  assign in_syn[0] = in_codeword[0] ^ in_codeword[2] ^ in_codeword[4] ^ in_codeword[6];
  assign in_syn[1] = in_codeword[1] ^ in_codeword[2] ^ in_codeword[5] ^ in_codeword[6];
  assign in_syn[2] = in_codeword[3] ^ in_codeword[4] ^ in_codeword[5] ^ in_codeword[6];

  assign s1_move  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_move;

  // Syndrome k selects position k (bit k-1); syndrome 0 lands on the dropped bit 0.
  assign syn_onehot = 8'd1 << s1_syn;
  assign fixed      = s1_code ^ syn_onehot[7:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_codeword;
        s1_syn  <= in_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
    end else if (s1_move) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data      <= {fixed[6], fixed[5], fixed[4], fixed[2]};
        out_syndrome  <= s1_syn;
        out_corrected <= |s1_syn;
      end
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic handshake;

  assign handshake = out_valid && out_ready;

  // Clear takes priority over a same-cycle handshake; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (stats_clr) begin
      word_count <= '0;
      corr_count <= '0;
    end else if (handshake) begin
      if (word_count != '1) word_count <= word_count + CNT_W'(1);
      if (out_corrected && (corr_count != '1)) corr_count <= corr_count + CNT_W'(1);
    end
  end
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign word_count       = '0;
  assign corr_count       = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed vector table, backpressure, reset and
// saturation sequences, plus randomized traffic scored against a position-XOR reference model.
module tb_hamming_decoder;

  localparam int CNT_W = 16;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       in_codeword;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic             out_corrected;
  logic             out_valid;
  logic             out_ready;
  logic             stats_clr;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] corr_count;

  logic [6:0] sat_in_codeword;
  logic       sat_in_valid;
  logic       sat_in_ready;
  logic [3:0] sat_out_data;
  logic [2:0] sat_out_syndrome;
  logic       sat_out_corrected;
  logic       sat_out_valid;
  logic       sat_out_ready;
  logic       sat_stats_clr;
  logic [1:0] sat_word_count;
  logic [1:0] sat_corr_count;

  int checks   = 0;
  int failures = 0;

  exp_t       exp_q[$];
  logic [6:0] send_q[$];
  int         exp_wc, exp_cc;
  logic       hold_pending;
  logic [3:0] hold_data;
  logic [2:0] hold_syn;
  logic       hold_corr;
  vec_t       vecs[10];

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_codeword(in_codeword), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_valid(out_valid), .out_ready(out_ready),
    .stats_clr(stats_clr), .word_count(word_count), .corr_count(corr_count)
  );

  hamming_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_codeword(sat_in_codeword), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .out_data(sat_out_data), .out_syndrome(sat_out_syndrome), .out_corrected(sat_out_corrected),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .stats_clr(sat_stats_clr), .word_count(sat_word_count), .corr_count(sat_corr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Syndrome is the XOR of the indices of every set position.
  function automatic logic [2:0] syndromeOf(input logic [6:0] cw);
    int s = 0;
    for (int p = 1; p <= 7; p++) if (cw[p-1]) s = s ^ p;
    return 3'(s);
  endfunction

  function automatic exp_t model(input logic [6:0] cw);
    exp_t       e;
    logic [2:0] s;
    logic [6:0] f;
    s = syndromeOf(cw);
    f = cw;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    e.data = {f[6], f[5], f[4], f[2]};
    e.syn  = s;
    e.corr = (s != 3'd0);
    return e;
  endfunction

  // Picks whichever parity triple gives a zero syndrome.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    for (int par = 0; par < 8; par++) begin
      cw = {d[3], d[2], d[1], par[2], d[0], par[1], par[0]};
      if (syndromeOf(cw) == 3'd0) return cw;
    end
    return '0;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    logic hs, hs_corr;
    if (!rst_n) begin
      exp_q.delete();
      exp_wc = 0;
      exp_cc = 0;
      hold_pending = 1'b0;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_word_count", 32'(word_count), 32'd0);
      checkOutput("reset_corr_count", 32'(corr_count), 32'd0);
    end else begin
      checkOutput("word_count", 32'(word_count), 32'(exp_wc));
      checkOutput("corr_count", 32'(corr_count), 32'(exp_cc));
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(hold_data));
        checkOutput("hold_syndrome", 32'(out_syndrome), 32'(hold_syn));
        checkOutput("hold_corrected", 32'(out_corrected), 32'(hold_corr));
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_syn     = out_syndrome;
      hold_corr    = out_corrected;
      hs      = out_valid && out_ready;
      hs_corr = 1'b0;
      if (hs) begin
        checkOutput("output_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          hs_corr = e.corr;
          checkOutput("sb_data", 32'(out_data), 32'(e.data));
          checkOutput("sb_syndrome", 32'(out_syndrome), 32'(e.syn));
          checkOutput("sb_corrected", 32'(out_corrected), 32'(e.corr));
        end
      end
      if (STATS) begin
        if (stats_clr) begin
          exp_wc = 0;
          exp_cc = 0;
        end else if (hs) begin
          if (exp_wc < (1 << CNT_W) - 1) exp_wc++;
          if (hs_corr && exp_cc < (1 << CNT_W) - 1) exp_cc++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_codeword));
    end
  end

  task automatic loadInput();
    if (send_q.size() != 0) begin
      in_valid    = 1'b1;
      in_codeword = send_q[0];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Called between posedge and negedge; returns at posedge+1 with the next word presented.
  task automatic stepCycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) void'(send_q.pop_front());
    loadInput();
  endtask

  // Single word through an empty pipeline with out_ready high; checks two-edge latency.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    in_codeword = v.cw;
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_not_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(v.data));
    checkOutput({tag, "_syndrome"}, 32'(out_syndrome), 32'(v.syn));
    checkOutput({tag, "_corrected"}, 32'(out_corrected), 32'(v.corr));
  endtask

  initial begin : watchdog
    #400000;
    failures++;
    $display("[TB] FAIL watchdog timeout reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    bit         acc;
    int         accepts;
    logic [3:0] bp_data[4];
    logic [3:0] d;
    logic [6:0] cw;
    int         a, b;

    vecs[0] = '{7'b0011110, 4'b0011, 3'd0, 1'b0};
    vecs[1] = '{7'b0101101, 4'b0101, 3'd0, 1'b0};
    vecs[2] = '{7'b1010011, 4'b1010, 3'd1, 1'b1};
    vecs[3] = '{7'b1010000, 4'b1010, 3'd2, 1'b1};
    vecs[4] = '{7'b1010110, 4'b1010, 3'd3, 1'b1};
    vecs[5] = '{7'b1011010, 4'b1010, 3'd4, 1'b1};
    vecs[6] = '{7'b1000010, 4'b1010, 3'd5, 1'b1};
    vecs[7] = '{7'b1110010, 4'b1010, 3'd6, 1'b1};
    vecs[8] = '{7'b0010010, 4'b1010, 3'd7, 1'b1};
    vecs[9] = '{7'b0001110, 4'b0011, 3'd5, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_codeword = '0;
    out_ready = 1'b1;
    stats_clr = 1'b0;
    sat_in_valid = 1'b0;
    sat_in_codeword = '0;
    sat_out_ready = 1'b1;
    sat_stats_clr = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_reset_out_data", 32'(out_data), 32'd0);
    checkOutput("post_reset_syndrome", 32'(out_syndrome), 32'd0);
    checkOutput("post_reset_corrected", 32'(out_corrected), 32'd0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    @(posedge clk);
    #1;
    checkOutput("table_word_count", 32'(word_count), STATS ? 32'd10 : 32'd0);
    checkOutput("table_corr_count", 32'(corr_count), STATS ? 32'd8 : 32'd0);

    // Backpressure: four words against a stalled sink for five cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bp_data[k] = 4'($urandom_range(0, 15));
      cw = encode(bp_data[k]);
      if (k % 2 == 1) cw[$urandom_range(0, 6)] ^= 1'b1;
      send_q.push_back(cw);
    end
    loadInput();
    accepts = 0;
    repeat (5) begin
      stepCycle(acc);
      accepts += int'(acc);
      if (out_valid) checkOutput("bp_hold_word0", 32'(out_data), 32'(bp_data[0]));
    end
    checkOutput("bp_accepts", 32'(accepts), 32'd2);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_no_gap", 32'(out_valid), 32'd1);
      checkOutput("bp_order", 32'(out_data), 32'(bp_data[k]));
      stepCycle(acc);
    end

    // Randomized traffic with random sink stalls and occasional clears.
    for (int c = 0; c < 400; c++) begin
      if (send_q.size() < 3 && $urandom_range(0, 1) == 1) begin
        d  = 4'($urandom_range(0, 15));
        cw = encode(d);
        case ($urandom_range(0, 7))
          0, 1, 2: ;
          7: begin
            a = $urandom_range(0, 6);
            b = (a + $urandom_range(1, 6)) % 7;
            cw[a] ^= 1'b1;
            cw[b] ^= 1'b1;
          end
          default: cw[$urandom_range(0, 6)] ^= 1'b1;
        endcase
        send_q.push_back(cw);
        loadInput();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 31) == 0);
      stepCycle(acc);
    end
    out_ready = 1'b1;
    stats_clr = 1'b0;
    for (int c = 0; c < 40 && (send_q.size() != 0 || exp_q.size() != 0); c++) stepCycle(acc);
    checkOutput("drain_complete", 32'(send_q.size() + exp_q.size()), 32'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send_q.push_back(vecs[4].cw);
    send_q.push_back(vecs[5].cw);
    loadInput();
    repeat (2) stepCycle(acc);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    send_q.delete();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_async_word_count", 32'(word_count), 32'd0);
    checkOutput("reset_async_corr_count", 32'(corr_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rerun_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rerun_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(vecs[9], "after_reset");

    // Saturation and clear-wins on the narrow-counter instance.
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      sat_in_valid    = 1'b1;
      sat_in_codeword = vecs[2 + k].cw;
      @(posedge clk);
      #1;
    end
    sat_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat_word_count", 32'(sat_word_count), STATS ? 32'd3 : 32'd0);
    checkOutput("sat_corr_count", 32'(sat_corr_count), STATS ? 32'd3 : 32'd0);
    sat_in_valid    = 1'b1;
    sat_in_codeword = vecs[8].cw;
    @(posedge clk);
    #1 sat_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sat_clr_handshake_pending", 32'(sat_out_valid), 32'd1);
    sat_stats_clr = 1'b1;
    @(posedge clk);
    #1 sat_stats_clr = 1'b0;
    checkOutput("sat_clr_word_count", 32'(sat_word_count), 32'd0);
    checkOutput("sat_clr_corr_count", 32'(sat_corr_count), 32'd0);
    sat_in_valid    = 1'b1;
    sat_in_codeword = vecs[0].cw;
    @(posedge clk);
    #1 sat_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_recount_word", 32'(sat_word_count), STATS ? 32'd1 : 32'd0);
    checkOutput("sat_recount_corr", 32'(sat_corr_count), 32'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Streaming Hamming [7,4] single-error-correcting decoder that sits directly downstream of `hamming_encoder` (after the channel or storage path) and recovers the 4-bit data word. It computes the 3-bit syndrome, flips the addressed bit, and delivers corrected data through a two-stage valid/ready pipeline with full backpressure. Optional saturating statistics counters track decoded and corrected words.

## Interface
- `CNT_W`, 16: width of the statistics counters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_codeword`  in  7  received codeword; bit p-1 holds Hamming position p (1..7).
- `in_valid`  in  1  `in_codeword` is valid.
- `in_ready`  out  1  decoder accepts a word this cycle.
- `out_data`  out  4  corrected data word.
- `out_syndrome`  out  3  syndrome of the word as received.
- `out_corrected`  out  1  syndrome was non-zero and one bit was flipped.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the output word.
- `stats_clr`  in  1  synchronous clear of both counters.
- `word_count`  out  CNT_W  words delivered (saturating).
- `corr_count`  out  CNT_W  delivered words with `out_corrected`=1 (saturating).

## Operation
- Codeword layout: parity at positions 1, 2, 4 (bits 0, 1, 3); data d0..d3 at positions 3, 5, 6, 7 (bits 2, 4, 5, 6). This is the layout `hamming_encoder` produces.
- Syndrome bits:
  - s0 = XOR of positions {1,3,5,7}.
  - s1 = XOR of positions {2,3,6,7}.
  - s2 = XOR of positions {4,5,6,7}.
  - syndrome = {s2,s1,s0}.
- Syndrome 0: no correction. Syndrome k (1..7): invert position k, then extract data. A parity-position error leaves data unchanged but still sets `out_corrected`=1.
- Double-bit errors are not detected; the block miscorrects them. This is inherent to [7,4] and is not a bug.
- Stage 1 registers the codeword and its syndrome. Stage 2 registers the corrected data, syndrome and flag.
- A stage loads when it is empty or its contents move on in the same cycle.
- `in_ready` = !s1_valid | (s1 moves to s2).
- s1 moves when !out_valid | out_ready.
- Words are never dropped, duplicated or reordered.
- Counters update only on an output handshake (`out_valid & out_ready`):
  - `word_count` increments by 1.
  - `corr_count` increments by 1 if `out_corrected`=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- `stats_clr`=1 zeroes both counters on the next edge. If a handshake occurs in the same cycle, clear wins and that event is not counted.

## Timing
- Reset values: `in_ready`=1 once reset is released (both stages empty). All other outputs are 0: `out_valid`, `out_data`, `out_syndrome`, `out_corrected`, `word_count`, `corr_count`.
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N+1 (two register stages). Throughput is one word per clock when `out_ready` is held high.
- Backpressure:
  - With `out_ready`=0, output data and flags hold stable while `out_valid`=1.
  - Stage 1 fills, then `in_ready` drops.
  - At most 2 words are in flight.
- `in_ready` may depend combinationally on `out_ready`. `out_valid` does not depend on `in_valid` in the same cycle.
- Reset asserted mid-operation: all in-flight words are discarded immediately and the counters clear. Operation resumes from the empty state on the first edge after `rst_n` rises.

## Configuration
- Macro: `HAMMING_DEC_STATS_EN`.
- Defined: counters are implemented as described above.
- Undefined:
  - No counter registers are built.
  - `word_count` and `corr_count` are tied to 0.
  - `stats_clr` is ignored.
  - The ports remain so that instantiations are identical in both builds.

## Test plan
- Clean words, `out_ready`=1: feed 7'b0011110 then 7'b0101101. Required output, 2 cycles after each accept:
  - `out_data` 4'b0011, then 4'b0101.
  - `out_syndrome`=0 and `out_corrected`=0 for both.
  - `word_count`=2.
- Single error sweep: encode 4'b1010 and flip each bit 0..6 in turn. Every output must be `out_data`=4'b1010 with `out_syndrome`=bit+1 and `out_corrected`=1. With stats enabled, `corr_count`=7. Example: 7'b0001110 (bit 4 flipped in 0x1E) gives syndrome 5 and data 4'b0011.
- Backpressure: stream 4 words with `out_ready` held 0 for 5 cycles.
  - `in_ready` falls after 2 accepts.
  - Output holds word 1 stable.
  - After release, all 4 words arrive in order with no gaps.
- Saturation and clear with CNT_W=2: deliver 5 words; `word_count` must stick at 3. Assert `stats_clr` on the same cycle as a handshake; both counters must read 0 on the next cycle.
- Reset mid-stream: assert `rst_n`=0 with 2 words in flight.
  - `out_valid` drops immediately.
  - Counters read 0.
  - After release, `in_ready`=1 and the next word decodes with 2-cycle latency.
- Build without `HAMMING_DEC_STATS_EN`: rerun the single-error sweep. Data must be identical and both counters must read 0 throughout.
